// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: FSM state
// encoding and default data/address widths.
package regfile_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_access_ctrl_decoder.sv
// regfile_addr_decoder: AW-bit address to one-hot R-bit enable vector.
// The output is all-zero whenever en is low, so a disabled decoder never
// selects a cell.
module regfile_addr_decoder
    import regfile_access_ctrl_pkg::*;
#(
    parameter int AW = ADDR_W_DEF
) (
    input  logic [AW-1:0]      addr,
    input  logic               en,
    output logic [(2**AW)-1:0] onehot
);

    localparam int R = 2**AW;

    // One-hot decode of the address, gated by the enable.
    always_comb begin
        onehot = {R{1'b0}};
        if (en) begin
            onehot[addr] = 1'b1;
        end else begin
            onehot = {R{1'b0}};
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: requester-side controller for a tri-state register
// file. One read-pair or one write is in flight at a time. Writes take one
// WRITE cycle; reads take one READ cycle followed by a RESP cycle that holds
// the captured bus data until the consumer accepts it.
// Optional build macro: REGFILE_ACCESS_CTRL_ZERO_R0_EN makes address 0 a
// hardwired zero register (writes suppressed, reads return 0 without
// enabling any cell).
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int N  = DATA_W_DEF,
    parameter int AW = ADDR_W_DEF
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic                ReqWrite,
    input  logic [AW-1:0]       ReqAddrA,
    input  logic [AW-1:0]       ReqAddrB,
    input  logic [AW-1:0]       ReqAddrW,
    input  logic [N-1:0]        ReqData,
    output logic [(2**AW)-1:0]  WS,
    output logic [(2**AW)-1:0]  ReadA,
    output logic [(2**AW)-1:0]  ReadB,
    output logic [N-1:0]        WrData,
    input  logic [N-1:0]        BusA,
    input  logic [N-1:0]        BusB,
    output logic                RspValid,
    input  logic                RspReady,
    output logic [N-1:0]        RspDataA,
    output logic [N-1:0]        RspDataB
);

    state_e          state_r;
    state_e          state_next_s;
    logic [AW-1:0]   addr_a_r;
    logic [AW-1:0]   addr_b_r;
    logic [AW-1:0]   addr_w_r;
    logic [N-1:0]    data_r;
    logic [N-1:0]    rsp_a_r;
    logic [N-1:0]    rsp_b_r;
    logic            accept_s;
    logic            ws_en_s;
    logic            rd_a_en_s;
    logic            rd_b_en_s;
    logic [N-1:0]    cap_a_s;
    logic [N-1:0]    cap_b_s;

    // Ready only in IDLE; forced low during reset so nothing is accepted.
    assign ReqReady = (state_r == ST_IDLE) && !Rst;
    assign accept_s = ReqValid && ReqReady;
    assign RspValid = (state_r == ST_RESP) && !Rst;
    assign RspDataA = rsp_a_r;
    assign RspDataB = rsp_b_r;

    // Next-state logic for the IDLE/WRITE/READ/RESP sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ReqWrite ? ST_WRITE : ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: state_next_s = ST_IDLE;
            ST_READ:  state_next_s = ST_RESP;
            ST_RESP: begin
                if (RspReady) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request fields are latched at the accepting edge and ignored afterwards.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            addr_a_r <= {AW{1'b0}};
            addr_b_r <= {AW{1'b0}};
            addr_w_r <= {AW{1'b0}};
            data_r   <= {N{1'b0}};
        end else if (accept_s) begin
            addr_a_r <= ReqAddrA;
            addr_b_r <= ReqAddrB;
            addr_w_r <= ReqAddrW;
            data_r   <= ReqData;
        end
    end

    // Decoder enables; reset gates them immediately so an in-flight write is
    // aborted in the very cycle Rst is seen.
    always_comb begin
        ws_en_s   = (state_r == ST_WRITE) && !Rst;
        rd_a_en_s = (state_r == ST_READ) && !Rst;
        rd_b_en_s = (state_r == ST_READ) && !Rst;
`ifdef REGFILE_ACCESS_CTRL_ZERO_R0_EN
        if (addr_w_r == {AW{1'b0}}) begin
            ws_en_s = 1'b0;
        end else begin
            ws_en_s = ws_en_s;
        end
        if (addr_a_r == {AW{1'b0}}) begin
            rd_a_en_s = 1'b0;
        end else begin
            rd_a_en_s = rd_a_en_s;
        end
        if (addr_b_r == {AW{1'b0}}) begin
            rd_b_en_s = 1'b0;
        end else begin
            rd_b_en_s = rd_b_en_s;
        end
`endif
    end

    regfile_addr_decoder #(.AW(AW)) u_dec_ws (
        .addr   (addr_w_r),
        .en     (ws_en_s),
        .onehot (WS)
    );

    regfile_addr_decoder #(.AW(AW)) u_dec_rda (
        .addr   (addr_a_r),
        .en     (rd_a_en_s),
        .onehot (ReadA)
    );

    regfile_addr_decoder #(.AW(AW)) u_dec_rdb (
        .addr   (addr_b_r),
        .en     (rd_b_en_s),
        .onehot (ReadB)
    );

    // Write-data bus carries the latched data only while a write is active.
    always_comb begin
        if (ws_en_s) begin
            WrData = data_r;
        end else begin
            WrData = {N{1'b0}};
        end
    end

    // Data to capture at the end of READ; a zero register returns 0 rather
    // than whatever the undriven bus holds.
    always_comb begin
        cap_a_s = BusA;
        cap_b_s = BusB;
`ifdef REGFILE_ACCESS_CTRL_ZERO_R0_EN
        if (addr_a_r == {AW{1'b0}}) begin
            cap_a_s = {N{1'b0}};
        end else begin
            cap_a_s = BusA;
        end
        if (addr_b_r == {AW{1'b0}}) begin
            cap_b_s = {N{1'b0}};
        end else begin
            cap_b_s = BusB;
        end
`endif
    end

    // Response registers: loaded at the end of READ, held through RESP.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rsp_a_r <= {N{1'b0}};
            rsp_b_r <= {N{1'b0}};
        end else if (state_r == ST_READ) begin
            rsp_a_r <= cap_a_s;
            rsp_b_r <= cap_b_s;
        end
    end

endmodule
